// File: rtl/nr_result_drain.sv
// nr_result_drain: buffers Newton-Raphson solver iterates in a 4-entry FIFO
// and drains each one as a 4-beat valid/ready packet (header, x0, x1, x2).
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   res_x0..res_x2, res_stb   iterate payload and its one-cycle strobe
//   clr_iter                  clears the iteration index (job start)
//   m_data, m_valid, m_last   registered output stream
//   m_ready                   sink ready; a beat moves on m_valid && m_ready
//   overflow, drop_count      sticky drop flag and saturating drop counter
module nr_result_drain (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] res_x0,
  input  logic [31:0] res_x1,
  input  logic [31:0] res_x2,
  input  logic        res_stb,
  input  logic        clr_iter,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned DCW   = 8;

  typedef struct packed {
    logic [IW-1:0] iter;
    logic          nan;
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    logic [DW-1:0] x2;
  } entry_t;

  typedef enum logic [2:0] {IDLE, HDR, X0, X1, X2} state_e;

  // Quiet or signalling NaN: all-ones exponent with non-zero mantissa.
  function automatic logic is_nan(input logic [DW-1:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, count_after_pop;
  logic [IW-1:0]   iter_q, iter_d;
  logic            overflow_q, overflow_d;
  logic [DCW-1:0]  drop_q, drop_d;
  state_e          state_q, state_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d, m_last_q, m_last_d;
  entry_t          new_entry, head_d;
  logic            xfer, pop, push;

  // FIFO bookkeeping, iteration index and drop accounting.
  always_comb begin
    new_entry      = '0;
    new_entry.iter = clr_iter ? '0 : iter_q;
    new_entry.nan  = is_nan(res_x0) || is_nan(res_x1) || is_nan(res_x2);
    new_entry.x0   = res_x0;
    new_entry.x1   = res_x1;
    new_entry.x2   = res_x2;

    xfer     = m_valid_q && m_ready;
    pop      = (state_q == X2) && xfer;
    // A full FIFO still takes the iterate when the head leaves this cycle.
    push     = res_stb && ((count_q < CW'(DEPTH)) || pop);

    count_after_pop = count_q - CW'(pop);
    count_d  = count_after_pop + CW'(push);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    // Head seen next cycle; bypass the incoming entry when the FIFO drains empty.
    head_d   = (count_after_pop == '0) ? new_entry : mem_q[rd_ptr_d];

    iter_d = iter_q;
    if (clr_iter)     iter_d = res_stb ? IW'(1) : '0;
    else if (res_stb) iter_d = iter_q + IW'(1);

    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (res_stb && !push) begin
      overflow_d = 1'b1;
      if (drop_q != {DCW{1'b1}}) drop_d = drop_q + DCW'(1);
    end
  end

  // Packet sequencer: next state plus next registered outputs.
  always_comb begin
    state_d   = state_q;
    m_valid_d = 1'b0;
    m_last_d  = 1'b0;
    m_data_d  = '0;

    case (state_q)
      IDLE:    if (count_d != '0) state_d = HDR;
      HDR:     if (xfer) state_d = X0;
      X0:      if (xfer) state_d = X1;
      X1:      if (xfer) state_d = X2;
      X2:      if (xfer) state_d = (count_d != '0) ? HDR : IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      HDR: begin
        m_valid_d = 1'b1;
        m_data_d  = {16'h4E52, head_d.nan, 9'd0, head_d.iter};
      end
      X0: begin
        m_valid_d = 1'b1;
        m_data_d  = head_d.x0;
      end
      X1: begin
        m_valid_d = 1'b1;
        m_data_d  = head_d.x1;
      end
      X2: begin
        m_valid_d = 1'b1;
        m_last_d  = 1'b1;
        m_data_d  = head_d.x2;
      end
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      iter_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      iter_q     <= iter_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_nr_result_drain.sv
// Bench for nr_result_drain: a packet-level reference model feeds an
// expected-beat queue; a separate monitor pops and compares on every transfer.
module tb_nr_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] res_x0, res_x1, res_x2;
  logic        res_stb, clr_iter, m_ready;
  logic [31:0] m_data;
  logic        m_valid, m_last, overflow;
  logic [7:0]  drop_count;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    beats_done = 0;  // beats transferred since reset
  int    accepted   = 0;  // packets accepted since reset
  int    iter_m     = 0;
  int    drops_m    = 0;
  bit    ovf_m      = 1'b0;

  always #5 clk = ~clk;

  nr_result_drain dut (
    .clk(clk), .rst(rst),
    .res_x0(res_x0), .res_x1(res_x1), .res_x2(res_x2),
    .res_stb(res_stb), .clr_iter(clr_iter),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .overflow(overflow), .drop_count(drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic bit nan_of(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] rnd_num();
    return $urandom & 32'hBFFF_FFFF;  // exponent < 0x80: never NaN
  endfunction

  function automatic logic [31:0] rnd_any();
    case ($urandom_range(0, 5))
      0:       return 32'h7FC0_0000 | ($urandom & 32'h0000_FFFF);
      1:       return 32'hFF80_0000;
      2:       return 32'h7F80_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic flush_model();
    exp_q.delete();
    beats_done = 0;
    accepted   = 0;
    iter_m     = 0;
    drops_m    = 0;
    ovf_m      = 1'b0;
  endtask

  // Packet-level model of one strobe: FIFO holds accepted-but-unfinished packets.
  task automatic model_strobe(input logic [31:0] a, b, c, input logic clr, input bit pop_now);
    int occ;
    int it;
    logic [31:0] hdr;
    occ = accepted - beats_done / 4;
    it  = clr ? 0 : iter_m;
    iter_m = (it + 1) % 64;
    if (occ < 4 || pop_now) begin
      accepted++;
      hdr = 32'h4E52_0000 + ((nan_of(a) || nan_of(b) || nan_of(c)) ? 32'h8000 : 32'h0) + 32'(it);
      exp_q.push_back('{data: hdr, last: 1'b0});
      exp_q.push_back('{data: a, last: 1'b0});
      exp_q.push_back('{data: b, last: 1'b0});
      exp_q.push_back('{data: c, last: 1'b1});
    end else begin
      ovf_m = 1'b1;
      if (drops_m < 255) drops_m++;
    end
  endtask

  task automatic drive(input logic stb, input logic [31:0] a, b, c, input logic clr, input logic rdy);
    bit pop_now;
    @(negedge clk);
    res_stb = stb; res_x0 = a; res_x1 = b; res_x2 = c;
    clr_iter = clr; m_ready = rdy;
    if (rst) begin
      pop_now = m_valid && rdy && (beats_done % 4 == 3);
      if (stb) model_strobe(a, b, c, clr, pop_now);
      else if (clr) iter_m = 0;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) drive(1'b0, '0, '0, '0, 1'b0, rdy);
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((exp_q.size() != 0 || m_valid) && c < maxc) begin
      drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
      c++;
    end
    check("drain_done", 32'((exp_q.size() == 0) && !m_valid), 32'd1);
  endtask

  task automatic start_reset();
    rst = 1'b0;
    flush_model();
  endtask

  task automatic end_reset();
    rst = 1'b1;
    res_stb = 1'b0;
    clr_iter = 1'b0;
  endtask

  // Monitor: compares every transfer and checks stability while stalled.
  initial begin : monitor
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    beat_t       e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (stall_prev) begin
          check("stall_valid", 32'(m_valid), 32'd1);
          check("stall_data", m_data, prev_data);
          check("stall_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", m_data, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_data, e.data);
            check("beat_last", 32'(m_last), 32'(e.last));
          end
          beats_done++;
        end
      end
      stall_prev = rst && m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin : stimulus
    logic [31:0] v;
    int          drops_before;
    rst = 1'b0; res_stb = 1'b0; clr_iter = 1'b0; m_ready = 1'b0;
    res_x0 = '0; res_x1 = '0; res_x2 = '0;
    flush_model();

    // Reset, with strobes that must be ignored.
    repeat (3) drive(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b1);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    end_reset();

    // Single iterate, minimum latency.
    drive(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("single_hdr_valid", 32'(m_valid), 32'd1);
    check("single_hdr", m_data, 32'h4E52_0000);
    idle(1, 1'b1); check("single_x0", m_data, 32'h3F80_0000);
    idle(1, 1'b1); check("single_x1", m_data, 32'h3F80_0000);
    idle(1, 1'b1); check("single_x2", m_data, 32'h3F80_0000);
    check("single_last", 32'(m_last), 32'd1);
    idle(1, 1'b1); check("single_idle", 32'(m_valid), 32'd0);

    // NaN flag at iter 5, then infinity at iter 5.
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, rnd_num(), rnd_num(), rnd_num(), 1'b0, 1'b1);
        drain(20);
      end
      v = (pass == 0) ? 32'h7FC0_0000 : 32'h7F80_0000;
      drive(1'b1, 32'h3F80_0000, v, 32'h4000_0000, 1'b0, 1'b1);
      idle(1, 1'b1);
      check(pass == 0 ? "nan_hdr" : "inf_hdr", m_data,
            pass == 0 ? 32'h4E52_8005 : 32'h4E52_0005);
      drain(20);
    end

    // Overflow: six strobes into a stalled sink.
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, rnd_num(), rnd_num(), rnd_num(), 1'b0, 1'b0);
    idle(1, 1'b0);
    check("ovf_drops", 32'(drop_count), 32'd2);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_hdr0", m_data, 32'h4E52_0000);
    for (int i = 0; i < 16; i++) begin
      idle(1, 1'b1);
      check("ovf_nogap", 32'(m_valid), 32'd1);
    end
    idle(1, 1'b1);
    check("ovf_after_idle", 32'(m_valid), 32'd0);
    drive(1'b1, rnd_num(), rnd_num(), rnd_num(), 1'b0, 1'b1);
    idle(1, 1'b1);
    check("ovf_next_iter6", m_data, 32'h4E52_0006);
    drain(20);

    // Backpressure: ready toggles every cycle.
    for (int i = 0; i < 3; i++) drive(1'b1, rnd_any(), rnd_any(), rnd_any(), 1'b0, 1'(i % 2));
    for (int i = 0; i < 30; i++) idle(1, 1'(i % 2));
    drain(40);

    // Full FIFO with a strobe coinciding with the head's final beat.
    for (int i = 0; i < 4; i++) drive(1'b1, rnd_num(), rnd_num(), rnd_num(), 1'b0, 1'b0);
    idle(1, 1'b0);
    drops_before = drops_m;
    check("full_drops_before", 32'(drop_count), 32'(drops_before));
    idle(3, 1'b1);
    drive(1'b1, rnd_num(), rnd_num(), rnd_num(), 1'b0, 1'b1);
    check("full_pop_last", 32'(m_last), 32'd1);
    idle(1, 1'b1);
    check("full_pop_drops", 32'(drop_count), 32'(drops_before));
    drain(60);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 2) == 0), rnd_any(), rnd_any(), rnd_any(),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    drain(200);
    check("model_drops", 32'(drop_count), 32'(drops_m));
    check("model_ovf", 32'(overflow), 32'(ovf_m));

    // Reset during the X1 beat.
    drive(1'b1, rnd_num(), rnd_num(), rnd_num(), 1'b0, 1'b1);
    drive(1'b1, rnd_num(), rnd_num(), rnd_num(), 1'b0, 1'b1);
    idle(2, 1'b1);
    start_reset();
    idle(1, 1'b1);
    check("midrst_valid", 32'(m_valid), 32'd0);
    end_reset();
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b1);
      check("midrst_empty", 32'(m_valid), 32'd0);
    end
    check("midrst_drops", 32'(drop_count), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    drive(1'b1, rnd_num(), rnd_num(), rnd_num(), 1'b0, 1'b1);
    idle(1, 1'b1);
    check("midrst_hdr_iter0", m_data, 32'h4E52_0000);
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nr_result_drain.md
NR_RESULT_DRAIN -- requirements
Module: nr_result_drain

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-004 SHALL have ports: res_x0, res_x1, res_x2  input  32 each  IEEE-754 single solver iterate (x0, x1, x2), valid only while res_stb=1.
REQ-005 SHALL have port: res_stb  input  1  one-cycle strobe: the solver has a new iterate on res_x0..2.
REQ-006 SHALL have port: clr_iter  input  1  clears the iteration index; used at solver job start.
REQ-007 SHALL have port: m_data  output  32  stream data word.
REQ-008 SHALL have port: m_valid  output  1  m_data is valid.
REQ-009 SHALL have port: m_ready  input  1  sink accepts the word; a beat transfers when m_valid&&m_ready.
REQ-010 SHALL have port: m_last  output  1  marks the final word of a packet.
REQ-011 SHALL have port: overflow  output  1  sticky; set when an iterate is dropped.
REQ-012 SHALL have port: drop_count  output  8  number of dropped iterates, saturating.

Function
REQ-013 SHALL buffer accepted iterates in a 4-entry FIFO; each entry = {iter[5:0], nan, x0, x1, x2}.
REQ-014 SHALL keep a 6-bit iter counter: it increments (mod 64, wraps 63->0) on every res_stb, accepted or dropped; the entry captures its pre-increment value.
REQ-015 SHALL clear iter to 0 on clr_iter; if clr_iter and res_stb occur together, the entry takes iter=0 and the counter becomes 1.
REQ-016 SHALL set the entry nan bit when any of x0..x2 has exponent 8'hFF and a non-zero mantissa; infinities SHALL NOT set it.
REQ-017 SHALL accept res_stb when FIFO count<4, or when count==4 and a pop occurs in the same cycle.
REQ-018 SHALL otherwise drop the iterate, set overflow, and increment drop_count, which saturates at 255.
REQ-019 SHALL serialize each entry as a 4-beat packet via FSM IDLE->HDR->X0->X1->X2.
REQ-020 SHALL use header word = {16'h4E52, nan, 9'd0, iter[5:0]}; the X0, X1, X2 beats carry the raw 32-bit values.
REQ-021 SHALL advance HDR->X0->X1->X2 only on a transfer; m_last=1 only in X2.
REQ-022 SHALL pop the FIFO on the X2 transfer, then go to HDR if the FIFO still holds an entry after the pop (no idle gap), else to IDLE.
REQ-023 SHALL leave IDLE for HDR in the cycle after the FIFO becomes non-empty; minimum latency is res_stb in cycle N -> header with m_valid=1 in cycle N+1.
REQ-024 SHALL hold m_valid, m_data and m_last stable while m_valid=1 and m_ready=0; m_valid SHALL NOT deassert mid-packet.
REQ-025 SHALL drive m_valid=0 in IDLE, and all outputs SHALL be registered.

Reset
REQ-026 SHALL, while rst=0 at a clock edge, empty the FIFO, go to IDLE, clear iter, overflow and drop_count, and drive m_valid=0, m_last=0, m_data=0.
REQ-027 SHALL abandon a packet interrupted by reset: no resumption after reset, and m_valid=0 in the cycle after the reset edge.
REQ-028 SHALL ignore res_stb during reset.

Verification
REQ-029 SHALL cover single iterate: x0=x1=x2=32'h3F800000, m_ready=1 -> cycles N+1..N+4 carry 32'h4E520000, 3F800000, 3F800000, 3F800000; m_last on the 4th; then m_valid=0.
REQ-030 SHALL cover NaN flag: x1=32'h7FC00000 at iter 5 -> header 32'h4E528005; with x1=32'h7F800000 (inf) -> header 32'h4E520005.
REQ-031 SHALL cover overflow: m_ready=0 while 6 strobes are issued -> 4 stored, drop_count=2, overflow=1; after release, headers carry iter 0,1,2,3, back-to-back with 16 beats and no gaps, and the next strobe carries iter 6.
REQ-032 SHALL cover backpressure: toggle m_ready every cycle mid-packet -> m_data/m_last stable while stalled, and the word order is unchanged.
REQ-033 SHALL cover full plus pop together: FIFO holds 4 entries, the X2 transfer of the head coincides with res_stb -> the iterate is accepted and drop_count is unchanged.
REQ-034 SHALL cover reset mid-packet: rst=0 during the X1 beat -> m_valid=0 the next cycle, the FIFO is empty, and the next strobe's header has iter=0.
